// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared FSM state type, select encodings and stats width for mux_arbiter.
package mux_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic SEL_REQ0 = 1'b0;
  localparam logic SEL_REQ1 = 1'b1;
  localparam int STAT_W = 16;
endpackage

// File: rtl/mux_arb_pick.sv
// mux_arb_pick: combinational round-robin winner picker with bounded burst ownership.
module mux_arb_pick
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W = 4
) (
  input  logic [1:0]       req_valid,
  input  state_t           state,
  input  logic [CNT_W-1:0] burst_cnt,
  input  logic             last_grant,
  output logic             winner,
  output logic             grant_valid
);
  logic own, keep;
  assign own = (state == OWN1) ? SEL_REQ1 : SEL_REQ0;
  // The owner keeps the grant until its burst is used up, unless nobody else wants it.
  assign keep = req_valid[own] && (burst_cnt < CNT_W'(MAX_BURST) || !req_valid[~own]);
  assign grant_valid = (state == IDLE) ? |req_valid : (keep || req_valid[~own]);
  assign winner = (state == IDLE) ? (&req_valid ? ~last_grant : req_valid[1]) : (keep ? own : ~own);
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin burst arbiter driving a 2:1 mux select and a registered valid/ready output.
// Optional grant statistics ports are enabled with `define MUX_ARB_STATS_EN.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel,
  output logic [1:0]        owner
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
`endif
);
  state_t state, state_d;
  logic [CNT_W-1:0] burst_cnt, cnt_d;
  logic last_grant, last_d, sel_q, winner, grant_valid, grant, load_en;

  assign load_en = !out_valid || out_ready;

  mux_arb_pick #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) u_pick (
    .req_valid  (req_valid),
    .state      (state),
    .burst_cnt  (burst_cnt),
    .last_grant (last_grant),
    .winner     (winner),
    .grant_valid(grant_valid)
  );

  assign grant = grant_valid && load_en;
  assign req_ready = grant ? ((winner == SEL_REQ1) ? 2'b10 : 2'b01) : 2'b00;
  assign sel = grant ? winner : sel_q;
  assign owner = {state == OWN1, state == OWN0};

  always_comb begin
    state_d = state;
    cnt_d = burst_cnt;
    last_d = last_grant;
    if (load_en) begin
      state_d = !grant ? IDLE : (winner ? OWN1 : OWN0);
      cnt_d = !grant ? '0 : (state_d == state && burst_cnt < CNT_W'(MAX_BURST)) ? burst_cnt + 1'b1 : CNT_W'(1);
      last_d = grant ? winner : last_grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      burst_cnt <= '0;
      last_grant <= 1'b1;
      sel_q <= SEL_REQ0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_d;
      burst_cnt <= cnt_d;
      last_grant <= last_d;
      sel_q <= sel;
      if (load_en) begin
        out_valid <= grant;
        if (grant) out_data <= winner ? req_data1 : req_data0;
      end
    end
  end

`ifdef MUX_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req_ready[0] && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req_ready[1] && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif
endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
Sequencing controller for the 2:1 multiplexer datapath. Two requesters compete for one shared output. The block picks a winner round-robin, holds it for bounded bursts, drives the mux select, and registers the selected beat toward a single downstream consumer using valid/ready handshakes. It sits directly in front of the mux and owns its select line.

Parameters:
DATA_W, 8, width of each requester data word and of the output word
MAX_BURST, 4, max consecutive beats one requester may win while the other is waiting; legal range 1..15
CNT_W, 4, width of the burst counter; must satisfy 2**CNT_W > MAX_BURST

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  2  bit i = requester i has a beat
req_data0  input  DATA_W  requester 0 data
req_data1  input  DATA_W  requester 1 data
req_ready  output  2  bit i = beat from requester i accepted this cycle
out_valid  output  1  registered beat available
out_data  output  DATA_W  registered selected data
out_ready  input  1  downstream accepts out_data
sel  output  1  mux select (0 = req_data0, 1 = req_data1)
owner  output  2  one-hot current owner; 00 in IDLE

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values: out_valid=0, out_data=0, sel=0, owner=00, state=IDLE, burst_cnt=0, last_grant=1 (so requester 0 wins first).
- load_en = !out_valid | out_ready. Arbitration and all state updates happen only on load_en cycles. Otherwise everything holds and req_ready=00.
- Winner w is computed combinationally. req_ready[w]=load_en, and at most one req_ready bit is high. sel=w while a grant exists, otherwise sel holds its last value.
- Accept cycle: out_data<=selected data and out_valid<=1. On a load_en cycle with no grant, out_valid<=0.
- Latency: 1 cycle from accept to out_valid. Sustained throughput: 1 beat/cycle with out_ready held high.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - No valid: stay.
  - One valid: grant it.
  - Both valid: grant !last_grant.
  - On grant: go to OWN_w, burst_cnt=1, last_grant=w.
- OWN_w, req_valid[w]=1 and burst_cnt<MAX_BURST: keep w, burst_cnt++.
- OWN_w, burst_cnt==MAX_BURST and other valid: switch to other, burst_cnt=1.
- OWN_w, burst_cnt==MAX_BURST and other idle: keep w, burst_cnt=1.
- OWN_w, req_valid[w]=0: switch to the other if it is valid (burst_cnt=1), else go to IDLE with burst_cnt=0. No bubble cycle on a switch.
- Backpressure (out_valid=1, out_ready=0): state frozen, no grant, requesters must hold.
- Reset asserted mid-burst: immediate return to reset values. Any in-flight out beat is dropped.
- MAX_BURST=1 degenerates to strict per-beat alternation when both requesters are valid.

Optional Feature:
MUX_ARB_STATS_EN
- Defined: adds output ports grant_cnt0 and grant_cnt1 (16 bits each). Each counter increments on an accepted beat from its requester, saturates at 16'hFFFF, and resets to 0.
- Undefined: these ports and their logic are absent. Core behaviour is identical in both builds.

Decomposition:
- Package mux_arb_pkg holds:
  - state enum (IDLE, OWN0, OWN1)
  - constants SEL_REQ0=1'b0 and SEL_REQ1=1'b1
  - the stats counter width constant
- One sub-module: mux_arb_pick, a combinational round-robin winner picker. Inputs: req_valid, state, burst_cnt, last_grant. Outputs: winner and grant_valid.
- The output register and FSM stay in mux_arbiter.

Test Plan:
- Reset then req_valid=01, req_data0=8'hA5, out_ready=1: req_ready=01 in cycle 0, out_valid=1 and out_data=8'hA5 in cycle 1, owner=01.
- Both valid continuously, MAX_BURST=4, out_ready=1: grants follow 0,0,0,0,1,1,1,1,0...; sel toggles every 4 accepts.
- Only req1 valid for 10 beats: continuous grants to 1, burst_cnt wraps 4→1, no bubbles.
- out_ready=0 for 3 cycles with out_valid=1: out_data stable, req_ready=00, state and burst_cnt unchanged; the next beat is accepted on the cycle out_ready rises.
- Owner 0 drops valid after 2 beats while req1 is valid: the very next load_en cycle grants 1 with burst_cnt=1; with req1 also idle → IDLE and owner=00.
- rst_n pulsed low mid-burst (burst_cnt=3, out_valid=1): outputs return to reset values asynchronously; after release, the first contention is won by requester 0.
